// File: rtl/phase_sequencer.sv
// phase_sequencer: steps each instruction through phases 1-5, parks in 0.
// Inputs: clk, rst (async active-low), run_btn, step_btn, step_mode, hlt,
//   mem_busy. Outputs: phase, running, halted, instr_count.
module phase_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_btn,
   input  logic             step_btn,
   input  logic             step_mode,
   input  logic             hlt,
   input  logic             mem_busy,
   output logic [2:0]       phase,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_HALT
   } state_t;

   state_t                 state_q, state_d;
   logic [2:0]             phase_q, phase_d;
   logic                   running_q, running_d;
   logic                   halted_q, halted_d;
   logic                   stop_pend_q, stop_pend_d;
   logic                   hlt_seen_q, hlt_seen_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] run_sync_q, run_sync_d;
   logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d;
   logic                   run_prev_q, run_prev_d;
   logic                   step_prev_q, step_prev_d;

   logic run_edge;
   logic step_edge;
   logic hlt_any;
   logic hold;
   logic boundary;

   // Edges come from registered state only, so each lasts one cycle.
   assign run_edge  = run_sync_q[SYNC_STAGES-1] & ~run_prev_q;
   assign step_edge = step_sync_q[SYNC_STAGES-1] & ~step_prev_q;

   always_comb begin
      run_sync_d  = {run_sync_q[SYNC_STAGES-2:0], run_btn};
      step_sync_d = {step_sync_q[SYNC_STAGES-2:0], step_btn};
      run_prev_d  = run_sync_q[SYNC_STAGES-1];
      step_prev_d = step_sync_q[SYNC_STAGES-1];
      state_d     = state_q;
      phase_d     = phase_q;
      halted_d    = halted_q;
      stop_pend_d = stop_pend_q;
      hlt_seen_d  = hlt_seen_q;
      cnt_d       = cnt_q;
      boundary    = 1'b0;
      // hlt may first appear in phase 5 itself, so fold in the live value.
      hlt_any     = hlt_seen_q | hlt;
      hold        = mem_busy & ((phase_q == 3'd1) | (phase_q == 3'd4));

      unique case (state_q)
         S_IDLE: begin
            if (run_edge && !step_mode) begin
               state_d = S_RUN;
               phase_d = 3'd1;
            end else if (step_edge && step_mode) begin
               state_d = S_STEP;
               phase_d = 3'd1;
            end
         end
         S_RUN, S_STEP: begin
            hlt_seen_d = hlt_any;
            if (state_q == S_RUN && run_edge) begin
               stop_pend_d = 1'b1;
            end
            if (phase_q == 3'd5) begin
               boundary = 1'b1;
            end else if (!hold) begin
               phase_d = phase_q + 3'd1;
            end
         end
         S_HALT: begin
         end
         default: begin
         end
      endcase

      if (boundary) begin
         cnt_d      = cnt_q + CNT_W'(1);
         hlt_seen_d = 1'b0;
         if (hlt_any) begin
            state_d     = S_HALT;
            phase_d     = 3'd0;
            halted_d    = 1'b1;
            stop_pend_d = 1'b0;
         end else if (state_q == S_STEP) begin
            state_d = S_IDLE;
            phase_d = 3'd0;
         end else if (stop_pend_q) begin
            state_d     = S_IDLE;
            phase_d     = 3'd0;
            stop_pend_d = 1'b0;
         end else begin
            phase_d = 3'd1;
         end
      end

      running_d = (phase_d != 3'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         phase_q     <= 3'd0;
         running_q   <= 1'b0;
         halted_q    <= 1'b0;
         stop_pend_q <= 1'b0;
         hlt_seen_q  <= 1'b0;
         cnt_q       <= '0;
         run_sync_q  <= '0;
         step_sync_q <= '0;
         run_prev_q  <= 1'b0;
         step_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         running_q   <= running_d;
         halted_q    <= halted_d;
         stop_pend_q <= stop_pend_d;
         hlt_seen_q  <= hlt_seen_d;
         cnt_q       <= cnt_d;
         run_sync_q  <= run_sync_d;
         step_sync_q <= step_sync_d;
         run_prev_q  <= run_prev_d;
         step_prev_q <= step_prev_d;
      end
   end

   assign phase       = phase_q;
   assign running     = running_q;
   assign halted      = halted_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed scenarios for phase_sequencer.
// Small counter width keeps the wrap scenario short.
module tb_phase_sequencer;

   localparam int CW = 6;

   logic          clk;
   logic          rst;
   logic          run_btn;
   logic          step_btn;
   logic          step_mode;
   logic          hlt;
   logic          mem_busy;
   logic [2:0]    phase;
   logic          running;
   logic          halted;
   logic [CW-1:0] instr_count;

   int n_pass;
   int n_total;
   logic [CW-1:0] exp_cnt;

   phase_sequencer #(
      .SYNC_STAGES(2),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .run_btn(run_btn),
      .step_btn(step_btn),
      .step_mode(step_mode),
      .hlt(hlt),
      .mem_busy(mem_busy),
      .phase(phase),
      .running(running),
      .halted(halted),
      .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_phase(input logic [2:0] p);
      int k;
      k = 0;
      while (phase !== p && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (phase !== p) begin
         n_total++;
         $display("FAIL wait_phase got %0d want %0d", phase, p);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      run_btn = 1'b0;
      step_btn = 1'b0;
      step_mode = 1'b0;
      hlt = 1'b0;
      mem_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (phase !== 3'd0)
         $display("FAIL reset_phase got %0d want 0", phase);
      else n_pass++;
      n_total++;
      if (running !== 1'b0 || halted !== 1'b0)
         $display("FAIL reset_flags got %b%b want 00", running, halted);
      else n_pass++;
      n_total++;
      if (instr_count !== '0)
         $display("FAIL reset_count got %0d want 0", instr_count);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      exp_cnt = '0;
   endtask

   task automatic test_start;
      logic [2:0]    ep;
      logic [CW-1:0] ec;
      run_btn = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         n_total++;
         if (phase !== 3'd0)
            $display("FAIL start_lat c%0d got %0d want 0", c, phase);
         else n_pass++;
      end
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         ep = 3'(((n - 1) % 5) + 1);
         ec = CW'((n - 1) / 5);
         n_total++;
         if (phase !== ep || running !== 1'b1)
            $display("FAIL start_phase n%0d got %0d/%b want %0d/1",
                     n, phase, running, ep);
         else n_pass++;
         n_total++;
         if (instr_count !== ec)
            $display("FAIL start_count n%0d got %0d want %0d",
                     n, instr_count, ec);
         else n_pass++;
         if (n == 2) run_btn = 1'b0;
      end
      exp_cnt = CW'(3);
   endtask

   task automatic test_stall;
      logic [2:0] ep [11];
      logic       bz [11];
      ep = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3,
             3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
      bz = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      wait_phase(3'd1);
      for (int i = 0; i < 11; i++) begin
         if (i > 0) @(negedge clk);
         n_total++;
         if (phase !== ep[i])
            $display("FAIL stall c%0d got %0d want %0d", i, phase, ep[i]);
         else n_pass++;
         mem_busy = bz[i];
      end
      exp_cnt = exp_cnt + CW'(1);
      n_total++;
      if (instr_count !== exp_cnt)
         $display("FAIL stall_count got %0d want %0d", instr_count, exp_cnt);
      else n_pass++;
   endtask

   // From phase 2 of RUN: press run, expect 3,4,5 then idle.
   task automatic stop_from_p2(input string tag);
      logic [2:0] ep [4];
      ep = '{3'd3, 3'd4, 3'd5, 3'd0};
      wait_phase(3'd2);
      run_btn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 2) run_btn = 1'b0;
         n_total++;
         if (phase !== ep[i])
            $display("FAIL %s_seq c%0d got %0d want %0d",
                     tag, i, phase, ep[i]);
         else n_pass++;
      end
      exp_cnt = exp_cnt + CW'(1);
      n_total++;
      if (running !== 1'b0 || instr_count !== exp_cnt)
         $display("FAIL %s_end got %b/%0d want 0/%0d",
                  tag, running, instr_count, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_stop;
      stop_from_p2("stop");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_total++;
         if (phase !== 3'd0)
            $display("FAIL stop_idle c%0d got %0d want 0", i, phase);
         else n_pass++;
      end
      run_btn = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_total++;
         if (phase !== ((c == 3) ? 3'd1 : 3'd0))
            $display("FAIL restart c%0d got %0d", c, phase);
         else n_pass++;
      end
      run_btn = 1'b0;
      stop_from_p2("restop");
   endtask

   task automatic test_step;
      logic [2:0] ep [10];
      ep = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
             3'd4, 3'd5, 3'd0, 3'd0, 3'd0};
      step_mode = 1'b1;
      step_btn = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         n_total++;
         if (phase !== ep[c-1])
            $display("FAIL step c%0d got %0d want %0d", c, phase, ep[c-1]);
         else n_pass++;
         if (c == 3) step_btn = 1'b0;
         if (c == 4) step_btn = 1'b1;
         if (c == 7) step_btn = 1'b0;
      end
      exp_cnt = exp_cnt + CW'(1);
      n_total++;
      if (instr_count !== exp_cnt)
         $display("FAIL step_count got %0d want %0d", instr_count, exp_cnt);
      else n_pass++;
      step_mode = 1'b0;
   endtask

   task automatic test_halt;
      logic [2:0] ep [8];
      ep = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
      run_btn = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         n_total++;
         if (phase !== ep[c-1])
            $display("FAIL halt_seq c%0d got %0d want %0d",
                     c, phase, ep[c-1]);
         else n_pass++;
         if (c == 3) run_btn = 1'b0;
         if (c == 4) run_btn = 1'b1;
         if (c == 5) hlt = 1'b1;
         if (c == 6) hlt = 1'b0;
         if (c == 7) run_btn = 1'b0;
      end
      exp_cnt = exp_cnt + CW'(1);
      n_total++;
      if (halted !== 1'b1 || running !== 1'b0)
         $display("FAIL halt_flags got %b%b want 10", halted, running);
      else n_pass++;
      n_total++;
      if (instr_count !== exp_cnt)
         $display("FAIL halt_count got %0d want %0d", instr_count, exp_cnt);
      else n_pass++;
      run_btn = 1'b1;
      repeat (4) @(negedge clk);
      run_btn = 1'b0;
      step_mode = 1'b1;
      step_btn = 1'b1;
      repeat (4) @(negedge clk);
      step_btn = 1'b0;
      repeat (3) @(negedge clk);
      step_mode = 1'b0;
      n_total++;
      if (phase !== 3'd0 || halted !== 1'b1)
         $display("FAIL halt_ignore got %0d/%b want 0/1", phase, halted);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if (halted !== 1'b0 || instr_count !== '0)
         $display("FAIL halt_reset got %b/%0d want 0/0", halted, instr_count);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      exp_cnt = '0;
      @(negedge clk);
   endtask

   task automatic test_wrap;
      int k;
      run_btn = 1'b1;
      repeat (4) @(negedge clk);
      run_btn = 1'b0;
      k = 0;
      while (instr_count !== {CW{1'b1}} && k < 600) begin
         @(negedge clk);
         k++;
      end
      n_total++;
      if (instr_count !== {CW{1'b1}})
         $display("FAIL wrap_preload got %0d want %0d",
                  instr_count, {CW{1'b1}});
      else n_pass++;
      wait_phase(3'd5);
      @(negedge clk);
      n_total++;
      if (instr_count !== '0 || phase !== 3'd1)
         $display("FAIL wrap got %0d/%0d want 0/1", instr_count, phase);
      else n_pass++;
      wait_phase(3'd4);
      #2;
      rst = 1'b0;
      #1;
      n_total++;
      if (phase !== 3'd0 || running !== 1'b0)
         $display("FAIL async_rst got %0d/%b want 0/0", phase, running);
      else n_pass++;
      n_total++;
      if (halted !== 1'b0 || instr_count !== '0)
         $display("FAIL async_rst_st got %b/%0d want 0/0",
                  halted, instr_count);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_start();
      test_stall();
      test_stop();
      test_step();
      test_halt();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
